// File: rtl/dosificador_multicanal_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dosificador_multicanal_pkg
// Brief   : Shared state encoding and constants for the dosing sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package dosificador_multicanal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN_SEQ = 2'd1,
    ST_RUN_PAR = 2'd2,
    ST_FIN     = 2'd3
  } estado_t;

  localparam logic MODO_SEQ     = 1'b0;
  localparam logic MODO_PAR     = 1'b1;
  localparam int   TICK_DIV_DEF = 5000000;

endpackage
`default_nettype wire

// File: rtl/dosificador_multicanal_tick.sv
`default_nettype none
// ============================================================================
// Module  : contador_tick
// Brief   : Free-running divider, tick high on the last count of each period.
// Revision: 1.0 - initial release
// ============================================================================
module contador_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = (r_cnt == C_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dosificador_multicanal.sv
`default_nettype none
// ============================================================================
// Module  : dosificador_multicanal
// Brief   : Multi-channel dosing sequencer, sequential or parallel motor runs.
// Revision: 1.0 - initial release
// ============================================================================
module dosificador_multicanal
  import dosificador_multicanal_pkg::*;
#(
  parameter  int N_CH     = 3,
  parameter  int W        = 5,
  parameter  int TICK_DIV = TICK_DIV_DEF,
  localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              modo,
  input  logic [N_CH*W-1:0] ciclos,
  output logic [N_CH-1:0]   motores,
  output logic [N_CH-1:0]   flags,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     canal
);

  estado_t         r_estado, w_estado_nxt;
  logic [W-1:0]    r_rem     [N_CH];
  logic [W-1:0]    w_rem_nxt [N_CH];
  logic [N_CH-1:0] w_nz, w_dec, w_nz_nxt;
  logic [CW-1:0]   w_activo;
  logic            w_hay_activo;
  logic            w_tick, w_clr, w_en, w_accept, w_run, w_handoff, w_fin_nxt;

  assign w_run    = (r_estado == ST_RUN_SEQ) || (r_estado == ST_RUN_PAR);
  assign w_accept = (r_estado == ST_IDLE) && start && !abort;
  assign w_en     = w_run;
  // Restart the tick period on accept and when a sequential channel hands off.
  assign w_clr    = w_accept || w_handoff;

  contador_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .en    (w_en),
    .tick  (w_tick)
  );

  always_comb begin
    w_activo     = '0;
    w_hay_activo = 1'b0;
    w_fin_nxt    = 1'b1;
    for (int k = N_CH - 1; k >= 0; k--) begin
      w_nz[k] = (r_rem[k] != '0);
      if (w_nz[k]) begin
        w_activo     = CW'(k);
        w_hay_activo = 1'b1;
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      w_dec[k] = w_tick && w_nz[k] &&
                 ((r_estado == ST_RUN_PAR) ||
                  ((r_estado == ST_RUN_SEQ) && (w_activo == CW'(k))));
      w_rem_nxt[k] = r_rem[k] - W'(w_dec[k]);
      w_nz_nxt[k]  = (w_rem_nxt[k] != '0);
      if (w_nz_nxt[k]) w_fin_nxt = 1'b0;
    end
    w_handoff = (r_estado == ST_RUN_SEQ) && |(w_dec & ~w_nz_nxt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_estado <= ST_IDLE;
    else        r_estado <= w_estado_nxt;
  end

  always_comb begin
    w_estado_nxt = r_estado;
    unique case (r_estado)
      ST_IDLE: begin
        if (w_accept) begin
          if (ciclos == '0)          w_estado_nxt = ST_FIN;
          else if (modo == MODO_PAR) w_estado_nxt = ST_RUN_PAR;
          else                       w_estado_nxt = ST_RUN_SEQ;
        end
      end
      ST_RUN_SEQ, ST_RUN_PAR: begin
        if (abort)          w_estado_nxt = ST_IDLE;
        else if (w_fin_nxt) w_estado_nxt = ST_FIN;
      end
      ST_FIN:  w_estado_nxt = ST_IDLE;
      default: w_estado_nxt = ST_IDLE;
    endcase
  end

  // Outputs trail the core state by one cycle so motors rise the cycle after accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_CH; k++) r_rem[k] <= '0;
      motores <= '0;
      flags   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      canal   <= '0;
    end else begin
      busy <= w_run;
      done <= (r_estado == ST_FIN) && !abort;
      if (r_estado == ST_RUN_PAR) begin
        motores <= w_nz;
      end else if ((r_estado == ST_RUN_SEQ) && w_hay_activo) begin
        motores <= N_CH'(1) << w_activo;
      end else begin
        motores <= '0;
      end
      canal <= (r_estado == ST_RUN_SEQ) ? w_activo : '0;
      if (w_accept) begin
        flags <= '0;
        for (int k = 0; k < N_CH; k++) r_rem[k] <= ciclos[k*W +: W];
      end else if (w_run || (r_estado == ST_FIN)) begin
        flags <= flags | ~w_nz;
        for (int k = 0; k < N_CH; k++) r_rem[k] <= w_rem_nxt[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dosificador_multicanal.sv
`default_nettype none
// ============================================================================
// Module  : tb_dosificador_multicanal
// Brief   : Self-checking bench against a closed-form timing model of the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dosificador_multicanal;

  localparam int N_CH = 3;
  localparam int W    = 5;
  localparam int TD   = 4;

  logic              clk = 1'b0;
  logic              reset, start, abort, modo;
  logic [N_CH*W-1:0] ciclos;
  logic [N_CH-1:0]   motores, flags;
  logic              busy, done;
  logic [1:0]        canal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dosificador_multicanal #(.N_CH(N_CH), .W(W), .TICK_DIV(TD)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .modo    (modo),
    .ciclos  (ciclos),
    .motores (motores),
    .flags   (flags),
    .busy    (busy),
    .done    (done),
    .canal   (canal)
  );

  // Expected {motores, flags, busy, done, canal} t cycles after the accepting edge.
  function automatic logic [9:0] modelo(input int t, input int c [N_CH], input bit par);
    int s, ini, fin, len;
    logic [2:0] m, f;
    logic [1:0] cn;
    logic b, d;
    s = 0; len = 0; m = '0; f = '0; cn = '0;
    for (int k = 0; k < N_CH; k++) begin
      ini = par ? 0 : s;
      fin = ini + c[k];
      if (!par) s = fin;
      if (fin > len) len = fin;
      if (c[k] == 0) begin
        f[k] = (t >= 1);
      end else begin
        if (t >= TD*ini + 1 && t <= TD*fin) begin
          m[k] = 1'b1;
          if (!par) cn = 2'(k);
        end
        f[k] = (t >= TD*fin + 1);
      end
    end
    b = (t >= 1) && (t <= TD*len);
    d = (len == 0) ? (t == 1) : (t == TD*len + 1);
    return {m, f, b, d, cn};
  endfunction

  function automatic int run_len(input int c [N_CH], input bit par);
    int len = 0;
    for (int k = 0; k < N_CH; k++) begin
      if (par) len = (c[k] > len) ? c[k] : len;
      else     len += c[k];
    end
    return len;
  endfunction

  task automatic test_dosing(input string name, input int c [N_CH], input bit par,
                             input int abort_at, input int start_at);
    int steps;
    logic [9:0] exp_v, obs, frozen;
    steps  = (abort_at > 0) ? abort_at + 3 : TD*run_len(c, par) + 3;
    frozen = modelo(abort_at, c, par);
    for (int k = 0; k < N_CH; k++) ciclos[k*W +: W] = W'(c[k]);
    modo  = par;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= steps; t++) begin
      if (t == abort_at) abort = 1'b1;
      if (t == start_at) begin
        start  = 1'b1;
        ciclos = 15'($urandom);
        modo   = ~modo;
      end
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      exp_v = modelo(t, c, par);
      if (abort_at > 0 && t > abort_at) exp_v = {3'b000, frozen[6:4], 4'b0000};
      obs = {motores, flags, busy, done, canal};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s t=%0d got mot=%b flg=%b busy=%b done=%b canal=%0d, want mot=%b flg=%b busy=%b done=%b canal=%0d",
                 name, t, obs[9:7], obs[6:4], obs[3], obs[2], obs[1:0],
                 exp_v[9:7], exp_v[6:4], exp_v[3], exp_v[2], exp_v[1:0]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0; modo = 1'b0; ciclos = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({motores, flags, busy, done, canal} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_state got %b want 0", {motores, flags, busy, done, canal});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_abort_start_idle();
    ciclos = {5'd1, 5'd1, 5'd1};
    modo   = 1'b1;
    start  = 1'b1;
    abort  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({motores, busy, done} !== 5'b0) begin
        n_fail++;
        $display("FAIL abort_start_idle t=%0d got mot=%b busy=%b done=%b want 0", t, motores, busy, done);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    ciclos = {5'd3, 5'd3, 5'd3};
    modo   = 1'b1;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({motores, flags, busy, done, canal} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run got %b want 0", {motores, flags, busy, done, canal});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({motores, flags, busy, done, canal} !== 10'b0) begin
        n_fail++;
        $display("FAIL reset_release t=%0d got %b want 0", t, {motores, flags, busy, done, canal});
      end
    end
  endtask

  task automatic test_random();
    int c [N_CH];
    int len, ab, st;
    bit par;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < N_CH; k++) c[k] = int'($urandom_range(0, 5));
      par = 1'($urandom_range(0, 1));
      len = run_len(c, par);
      ab  = 0;
      st  = 0;
      if (len > 0) begin
        if ($urandom_range(0, 2) == 0) ab = int'($urandom_range(1, TD*len));
        else if ($urandom_range(0, 1) == 1) st = int'($urandom_range(2, TD*len));
      end
      test_dosing("random", c, par, ab, st);
    end
  endtask

  initial begin
    test_reset();
    test_dosing("parallel", '{2, 1, 3}, 1'b1, 0, 0);
    test_dosing("sequential", '{2, 1, 3}, 1'b0, 0, 0);
    test_dosing("seq_zero_skip", '{0, 3, 0}, 1'b0, 0, 0);
    test_dosing("all_zero", '{0, 0, 0}, 1'b0, 0, 0);
    test_dosing("par_abort", '{5, 5, 1}, 1'b1, 6, 0);
    test_dosing("after_abort", '{1, 2, 1}, 1'b0, 0, 0);
    test_dosing("start_while_busy", '{1, 3, 2}, 1'b1, 0, 5);
    test_dosing("seq_start_busy", '{2, 0, 2}, 1'b0, 0, 9);
    test_abort_start_idle();
    test_reset_mid_run();
    test_dosing("after_reset", '{1, 1, 1}, 1'b1, 0, 0);
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
